// File: rtl/qpix_serial_loader_if.sv
// Bus bundle between the register file (master) and the Q-Pix serial loader
// (slave): register-level strobes, the configuration word, the ASIC-side
// serial pins, the readback word and the status flags.
interface qpix_serial_loader_if;
    logic        load_sr;
    logic        xmit;
    logic [31:0] data_in;
    logic        load_data;
    logic        rb_start;
    logic        sdi;
    logic        sdo;
    logic        sclk;
    logic        load_data_o;
    logic [31:0] rb_data;
    logic        busy;
    logic        done;

    modport master (
        output load_sr, xmit, data_in, load_data, rb_start, sdi,
        input  sdo, sclk, load_data_o, rb_data, busy, done
    );

    modport slave (
        input  load_sr, xmit, data_in, load_data, rb_start, sdi,
        output sdo, sclk, load_data_o, rb_data, busy, done
    );
endinterface

// File: rtl/qpix_serial_loader.sv
// Q-Pix serial configuration loader.
// Shifts a 32-bit word out MSB first on sdo/sclk, optionally reads a 32-bit
// word back on sdi, and generates the loadData one-shot for the ASIC.
// Optional feature macro: QPIX_READBACK_EN (adds the RB state, sdi path and
// rb_data register; when undefined rb_start/sdi are ignored, rb_data = 0).
module qpix_serial_loader #(
    parameter int CLK_DIV        = 25,
    parameter int LOAD_PULSE_CYC = 5000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    qpix_serial_loader_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, RB, HOLD} state_t;

    localparam int          NSTB     = 4;
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam int          LD_W     = (LOAD_PULSE_CYC > 1) ? $clog2(LOAD_PULSE_CYC) : 1;

    // Strobe index map: 0 load_sr, 1 xmit, 2 load_data, 3 rb_start
    logic [NSTB-1:0] stb_in;
    logic [NSTB-1:0] stb_level;
    logic [NSTB-1:0] stb_edge;

    assign stb_in = {bus.rb_start, bus.load_data, bus.xmit, bus.load_sr};

    generate
        for (genvar gi = 0; gi < NSTB; gi++) begin : g_stb
            logic q_reg;
            logic prev_reg;
            // Register each strobe once and keep the previous sample for edge detection
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg    <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    q_reg    <= stb_in[gi];
                    prev_reg <= q_reg;
                end
            end
            assign stb_level[gi] = q_reg;
            assign stb_edge[gi]  = q_reg & ~prev_reg;
        end
    endgenerate

    logic load_edge, xmit_edge, ld_edge, xmit_lvl;
    assign load_edge = stb_edge[0];
    assign xmit_edge = stb_edge[1];
    assign ld_edge   = stb_edge[2];
    assign xmit_lvl  = stb_level[1];

    state_t      state_reg, state_next;
    logic [7:0]  div_cnt_reg, div_cnt_next;
    logic        phase_reg, phase_next;       // 0: sclk low half, 1: sclk high half
    logic [4:0]  bitcnt_reg, bitcnt_next;
    logic [31:0] sr_reg, sr_next;
    logic        sdo_reg, sdo_next;
    logic        sclk_reg, sclk_next;
    logic        done_reg, done_next;
    logic        bit_end;
    logic        hold_exit;

`ifdef QPIX_READBACK_EN
    logic        rb_edge, rb_lvl;
    logic        hold_rb_reg, hold_rb_next;   // remembers whether HOLD came from RB
    logic [31:0] rb_shift_reg, rb_shift_next;
    logic [31:0] rb_data_reg, rb_data_next;

    assign rb_edge   = stb_edge[3];
    assign rb_lvl    = stb_level[3];
    assign hold_exit = hold_rb_reg ? !rb_lvl : !xmit_lvl;
`else
    logic unused_rb;
    assign unused_rb = &{1'b0, stb_edge[3], stb_level[3], bus.sdi};
    assign hold_exit = !xmit_lvl;
`endif

    assign bit_end = (div_cnt_reg == DIV_LAST);

    // Next-state and registered-output logic for the transfer FSM
    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        phase_next   = phase_reg;
        bitcnt_next  = bitcnt_reg;
        sr_next      = sr_reg;
        sdo_next     = sdo_reg;
        sclk_next    = sclk_reg;
        done_next    = 1'b0;
`ifdef QPIX_READBACK_EN
        hold_rb_next  = hold_rb_reg;
        rb_shift_next = rb_shift_reg;
        rb_data_next  = rb_data_reg;
`endif
        case (state_reg)
            IDLE: begin
                sdo_next  = 1'b0;
                sclk_next = 1'b0;
                if (load_edge) begin
                    sr_next = bus.data_in;
                end
                if (xmit_edge) begin
                    // xmit wins over a coincident rb_start edge
                    state_next   = SHIFT;
                    div_cnt_next = 8'd0;
                    phase_next   = 1'b0;
                    bitcnt_next  = 5'd0;
                    sdo_next     = load_edge ? bus.data_in[31] : sr_reg[31];
`ifdef QPIX_READBACK_EN
                    hold_rb_next = 1'b0;
                end else if (rb_edge) begin
                    state_next    = RB;
                    div_cnt_next  = 8'd0;
                    phase_next    = 1'b0;
                    bitcnt_next   = 5'd0;
                    hold_rb_next  = 1'b1;
                    rb_shift_next = '0;
`endif
                end
            end
            SHIFT: begin
                if (!xmit_lvl) begin
                    // Abort: keep partially rotated sr, no done pulse
                    state_next = IDLE;
                    sclk_next  = 1'b0;
                    sdo_next   = 1'b0;
                end else if (bit_end) begin
                    div_cnt_next = 8'd0;
                    if (!phase_reg) begin
                        phase_next = 1'b1;
                        sclk_next  = 1'b1;
                    end else begin
                        phase_next = 1'b0;
                        sclk_next  = 1'b0;
                        sr_next    = {sr_reg[30:0], sr_reg[31]};
                        if (bitcnt_reg == 5'd31) begin
                            done_next  = 1'b1;
                            sdo_next   = 1'b0;
                            state_next = HOLD;
                        end else begin
                            bitcnt_next = bitcnt_reg + 5'd1;
                            sdo_next    = sr_reg[30];
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end
            end
`ifdef QPIX_READBACK_EN
            RB: begin
                sdo_next = 1'b0;
                // Sample sdi in the first cycle of each sclk high half
                if (phase_reg && div_cnt_reg == 8'd0) begin
                    rb_shift_next = {rb_shift_reg[30:0], bus.sdi};
                end
                if (bit_end) begin
                    div_cnt_next = 8'd0;
                    if (!phase_reg) begin
                        phase_next = 1'b1;
                        sclk_next  = 1'b1;
                    end else begin
                        phase_next = 1'b0;
                        sclk_next  = 1'b0;
                        if (bitcnt_reg == 5'd31) begin
                            done_next    = 1'b1;
                            rb_data_next = rb_shift_next;
                            state_next   = HOLD;
                        end else begin
                            bitcnt_next = bitcnt_reg + 5'd1;
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end
            end
`endif
            HOLD: begin
                sclk_next = 1'b0;
                sdo_next  = 1'b0;
                if (hold_exit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                sclk_next  = 1'b0;
                sdo_next   = 1'b0;
            end
        endcase
    end

    // FSM state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            div_cnt_reg <= 8'd0;
            phase_reg   <= 1'b0;
            bitcnt_reg  <= 5'd0;
            sr_reg      <= '0;
            sdo_reg     <= 1'b0;
            sclk_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            phase_reg   <= phase_next;
            bitcnt_reg  <= bitcnt_next;
            sr_reg      <= sr_next;
            sdo_reg     <= sdo_next;
            sclk_reg    <= sclk_next;
            done_reg    <= done_next;
        end
    end

`ifdef QPIX_READBACK_EN
    // Readback shift and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_rb_reg  <= 1'b0;
            rb_shift_reg <= '0;
            rb_data_reg  <= '0;
        end else begin
            hold_rb_reg  <= hold_rb_next;
            rb_shift_reg <= rb_shift_next;
            rb_data_reg  <= rb_data_next;
        end
    end
    assign bus.rb_data = rb_data_reg;
`else
    assign bus.rb_data = '0;
`endif

    logic            ld_reg;
    logic [LD_W-1:0] ld_cnt_reg;

    // loadData one-shot: independent of the FSM, retrigger ignored while high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_reg     <= 1'b0;
            ld_cnt_reg <= '0;
        end else if (!ld_reg) begin
            if (ld_edge) begin
                ld_reg     <= 1'b1;
                ld_cnt_reg <= LD_W'(LOAD_PULSE_CYC - 1);
            end
        end else if (ld_cnt_reg == '0) begin
            ld_reg <= 1'b0;
        end else begin
            ld_cnt_reg <= ld_cnt_reg - LD_W'(1);
        end
    end

    assign bus.sdo         = sdo_reg;
    assign bus.sclk        = sclk_reg;
    assign bus.done        = done_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.load_data_o = ld_reg;

endmodule

// File: tb/tb_qpix_serial_loader.sv
// Directed testbench for qpix_serial_loader (CLK_DIV=2, LOAD_PULSE_CYC=5000).
// Readback checks follow QPIX_READBACK_EN like the design does.
module tb_qpix_serial_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qpix_serial_loader_if bus();

    qpix_serial_loader #(
        .CLK_DIV        (2),
        .LOAD_PULSE_CYC (5000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int check_cnt = 0;
    int error_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic pulse_load_sr(input logic [31:0] word);
        bus.data_in = word;
        bus.load_sr = 1'b1;
        repeat (2) @(negedge clk);
        bus.load_sr = 1'b0;
        bus.data_in = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
    endtask

    // Observe one transfer window: sdo captured at each sclk rise, sdi stepped
    // on each sclk fall, done timing measured from the first busy cycle.
    task automatic capture(input logic [31:0] sdi_pat, output logic [31:0] bits,
                           output int rises, output int dcyc, output int dones,
                           output logic [31:0] rb_at_done);
        logic        prev;
        int          start;
        logic [31:0] sh;
        bits = '0; rises = 0; dcyc = -1; dones = 0; start = -1;
        prev = 1'b0; rb_at_done = '0; sh = sdi_pat;
        bus.sdi = sh[31];
        for (int n = 0; n < 170; n++) begin
            @(negedge clk);
            if (bus.busy && start < 0) start = n;
            if (bus.sclk && !prev) begin
                bits = {bits[30:0], bus.sdo};
                rises++;
            end
            if (!bus.sclk && prev) begin
                sh = {sh[30:0], 1'b0};
                bus.sdi = sh[31];
            end
            prev = bus.sclk;
            if (bus.done) begin
                dones++;
                if (dcyc < 0) dcyc = n - start;
                rb_at_done = bus.rb_data;
            end
        end
    endtask

    logic [31:0] bits, rbd, d, exp_rb;
    int rises, dcyc, dones, cnt_a, cnt_b;
    logic prev;

    initial begin
        bus.load_sr = 1'b0; bus.xmit = 1'b0; bus.data_in = '0;
        bus.load_data = 1'b0; bus.rb_start = 1'b0; bus.sdi = 1'b0;
        exp_rb = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sdo",   32'(bus.sdo), 0);
        chk("rst_sclk",  32'(bus.sclk), 0);
        chk("rst_ldo",   32'(bus.load_data_o), 0);
        chk("rst_rb",    bus.rb_data, 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_done",  32'(bus.done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic shift of 0x12345678
        pulse_load_sr(32'h1234_5678);
        chk("idle_sdo", 32'(bus.sdo), 0);
        bus.xmit = 1'b1;
        capture(32'h0, bits, rises, dcyc, dones, rbd);
        chk("shift_bits",  bits, 32'h1234_5678);
        chk("shift_rises", 32'(rises), 32);
        chk("shift_dcyc",  32'(dcyc), 128);
        chk("shift_dones", 32'(dones), 1);
        chk("hold_busy",   32'(bus.busy), 1);
        chk("hold_sclk",   32'(bus.sclk), 0);
        bus.xmit = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_exit_busy", 32'(bus.busy), 0);

        // Full rotation restored sr: transmit again without reloading
        repeat (2) @(negedge clk);
        bus.xmit = 1'b1;
        capture(32'h0, bits, rises, dcyc, dones, rbd);
        chk("restore_bits", bits, 32'h1234_5678);
        bus.xmit = 1'b0;
        repeat (3) @(negedge clk);

        // Coincident load_sr and xmit edges
        bus.data_in = 32'hCAFE_F00D;
        bus.load_sr = 1'b1;
        bus.xmit = 1'b1;
        capture(32'h0, bits, rises, dcyc, dones, rbd);
        chk("coinc_bits",  bits, 32'hCAFE_F00D);
        chk("coinc_dones", 32'(dones), 1);
        bus.xmit = 1'b0; bus.load_sr = 1'b0;
        repeat (3) @(negedge clk);

        // Abort after 10 sclk pulses
        pulse_load_sr(32'h1234_5678);
        bus.xmit = 1'b1;
        cnt_a = 0; prev = 1'b0;
        for (int n = 0; n < 200 && cnt_a < 10; n++) begin
            @(negedge clk);
            if (bus.sclk && !prev) cnt_a++;
            prev = bus.sclk;
        end
        chk("abort_reach10", 32'(cnt_a), 10);
        bus.xmit = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_sclk", 32'(bus.sclk), 0);
        chk("abort_sdo",  32'(bus.sdo), 0);
        cnt_a = 0; cnt_b = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.done) cnt_a++;
            if (bus.sclk) cnt_b++;
        end
        chk("abort_no_done", 32'(cnt_a), 0);
        chk("abort_no_sclk", 32'(cnt_b), 0);
        // Nine rotations completed before the abort took effect
        d = 32'h1234_5678;
        bus.xmit = 1'b1;
        capture(32'h0, bits, rises, dcyc, dones, rbd);
        chk("abort_sr_kept", bits, {d[22:0], d[31:23]});
        bus.xmit = 1'b0;
        repeat (3) @(negedge clk);

        // loadData one-shot with a retrigger 100 cycles in
        bus.load_data = 1'b1;
        cnt_a = 0; cnt_b = 0; prev = 1'b0;
        for (int n = 0; n < 5300; n++) begin
            @(negedge clk);
            if (n == 3)   bus.load_data = 1'b0;
            if (n == 100) bus.load_data = 1'b1;
            if (n == 103) bus.load_data = 1'b0;
            if (bus.load_data_o) cnt_a++;
            if (bus.load_data_o && !prev) cnt_b++;
            prev = bus.load_data_o;
        end
        chk("ld_width",  32'(cnt_a), 5000);
        chk("ld_pulses", 32'(cnt_b), 1);

`ifdef QPIX_READBACK_EN
        // Readback of 0xA0A0A0AF
        bus.rb_start = 1'b1;
        capture(32'hA0A0_A0AF, bits, rises, dcyc, dones, rbd);
        chk("rb_at_done", rbd, 32'hA0A0_A0AF);
        chk("rb_dones",   32'(dones), 1);
        chk("rb_dcyc",    32'(dcyc), 128);
        chk("rb_rises",   32'(rises), 32);
        chk("rb_sdo_low", bits, 0);
        chk("rb_hold",    32'(bus.busy), 1);
        bus.rb_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rb_exit_busy", 32'(bus.busy), 0);
        chk("rb_data_kept", bus.rb_data, 32'hA0A0_A0AF);
        exp_rb = 32'hA0A0_A0AF;
`else
        // Readback absent: rb_start must be ignored
        bus.rb_start = 1'b1;
        bus.sdi = 1'b1;
        cnt_a = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.busy) cnt_a++;
        end
        chk("rb_ignored_busy", 32'(cnt_a), 0);
        chk("rb_tied_zero",    bus.rb_data, 0);
        bus.rb_start = 1'b0;
        bus.sdi = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Coincident xmit and rb_start: shift wins, rb_data unchanged
        pulse_load_sr(32'h0F0F_1234);
        bus.xmit = 1'b1;
        bus.rb_start = 1'b1;
        capture(32'hFFFF_FFFF, bits, rises, dcyc, dones, rbd);
        chk("xr_bits",  bits, 32'h0F0F_1234);
        chk("xr_dones", 32'(dones), 1);
        chk("xr_rb",    bus.rb_data, exp_rb);
        bus.xmit = 1'b0;
        bus.rb_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("xr_idle", 32'(bus.busy), 0);

        // Asynchronous reset in the middle of SHIFT
        pulse_load_sr(32'h55AA_55AA);
        bus.load_data = 1'b1;
        bus.xmit = 1'b1;
        cnt_a = 0; prev = 1'b0;
        for (int n = 0; n < 200 && cnt_a < 5; n++) begin
            @(negedge clk);
            if (bus.sclk && !prev) cnt_a++;
            prev = bus.sclk;
        end
        chk("mid_ldo_high", 32'(bus.load_data_o), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_sclk", 32'(bus.sclk), 0);
        chk("mrst_sdo",  32'(bus.sdo), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_done", 32'(bus.done), 0);
        chk("mrst_ldo",  32'(bus.load_data_o), 0);
        chk("mrst_rb",   bus.rb_data, 0);
        bus.xmit = 1'b0;
        bus.load_data = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.busy) cnt_a++;
            if (bus.sclk) cnt_b++;
        end
        chk("post_rst_idle", 32'(cnt_a), 0);
        chk("post_rst_sclk", 32'(cnt_b), 0);
        // sr was cleared by reset
        bus.xmit = 1'b1;
        capture(32'h0, bits, rises, dcyc, dones, rbd);
        chk("post_rst_bits",  bits, 0);
        chk("post_rst_dones", 32'(dones), 1);
        bus.xmit = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
